// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_pkg: pointer-width and RAM-slice geometry helpers for sync_fifo_param
package sync_fifo_pkg;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int nslice(input int data_w, input int slice_w);
    return (data_w + slice_w - 1) / slice_w;
  endfunction
  function automatic int slice_lo(input int k, input int slice_w);
    return k * slice_w;
  endfunction
  function automatic int slice_hi(input int k, input int data_w, input int slice_w);
    return (((k + 1) * slice_w < data_w) ? (k + 1) * slice_w : data_w) - 1;
  endfunction
endpackage

// File: rtl/sync_fifo_param_ram_slice.sv
// fifo_ram_slice: one block-RAM-shaped slice, single write port plus registered read port
module fifo_ram_slice #(
  parameter int W     = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // only the output register is reset; the array stays reset-free for inference
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised synchronous FIFO with sliced RAM, fill count and threshold flags
// Define SYNC_FIFO_ERR_STICKY_EN to add sticky overflow/underflow outputs.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W     = 80,
  parameter int DEPTH      = 32,
  parameter int SLICE_W    = 32,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     dout_valid,
  output logic                     emp,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [ptr_w(DEPTH):0]    count
`ifdef SYNC_FIFO_ERR_STICKY_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam int NS = nslice(DATA_W, SLICE_W);
  localparam logic [PW:0] AF = CW'(AFULL_THR);
  localparam logic [PW:0] AE = CW'(AEMPTY_THR);
  logic [PW:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign emp          = wr_ptr == rd_ptr;
  assign full         = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign wr_en        = wr & ~full;
  assign rd_en        = rd & ~emp;
  assign almost_empty = count <= AE;
  assign almost_full  = count >= AF;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en != rd_en) count <= wr_en ? count + 1'b1 : count - 1'b1;
      dout_valid <= rd_en;
    end
  for (genvar k = 0; k < NS; k++) begin : g_slice
    localparam int LO = slice_lo(k, SLICE_W);
    localparam int HI = slice_hi(k, DATA_W, SLICE_W);
    fifo_ram_slice #(.W(HI - LO + 1), .DEPTH(DEPTH)) u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .waddr (wr_ptr[PW-1:0]),
      .wdata (data_in[HI:LO]),
      .re    (rd_en),
      .raddr (rd_ptr[PW-1:0]),
      .rdata (data_out[HI:LO])
    );
  end
`ifdef SYNC_FIFO_ERR_STICKY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (wr & full);
      underflow <= underflow | (rd & emp);
    end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed + random checks of sync_fifo_param against a queue model
module tb_sync_fifo_param;
  localparam int DW = 80;
  localparam int D  = 32;
  localparam logic [DW-1:0] PAT = 80'hA5A5_A5A5_A5A5_A5A5_A55A;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic wr = 1'b0, rd = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic dout_valid, emp, full, almost_empty, almost_full;
  logic [5:0] count;
`ifdef SYNC_FIFO_ERR_STICKY_EN
  logic overflow, underflow;
`endif
  int total = 0, bad = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout = '0;
  logic exp_dv = 1'b0, exp_ov = 1'b0, exp_un = 1'b0;
  always #5 clk = ~clk;
  sync_fifo_param dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(data_out), .dout_valid(dout_valid), .emp(emp), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count)
`ifdef SYNC_FIFO_ERR_STICKY_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );
  task automatic chk(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic check_all();
    chk("count", DW'(count), DW'(q.size()));
    chk("emp", DW'(emp), DW'(q.size() == 0));
    chk("full", DW'(full), DW'(q.size() == D));
    chk("almost_empty", DW'(almost_empty), DW'(q.size() <= 2));
    chk("almost_full", DW'(almost_full), DW'(q.size() >= D - 2));
    chk("dout_valid", DW'(dout_valid), DW'(exp_dv));
    chk("data_out", data_out, exp_dout);
`ifdef SYNC_FIFO_ERR_STICKY_EN
    chk("overflow", DW'(overflow), DW'(exp_ov));
    chk("underflow", DW'(underflow), DW'(exp_un));
`endif
  endtask
  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
    bit fm, em;
    wr = w;
    rd = r;
    data_in = d;
    fm = q.size() == D;
    em = q.size() == 0;
    @(posedge clk);
    #1;
    exp_ov = exp_ov | (w & fm);
    exp_un = exp_un | (r & em);
    exp_dv = r & !em;
    if (r && !em) exp_dout = q.pop_front();
    if (w && !fm) q.push_back(d);
    check_all();
  endtask
  function automatic logic [DW-1:0] rnd();
    logic [95:0] v;
    v = {$urandom(), $urandom(), $urandom()};
    return v[DW-1:0];
  endfunction
  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_dv = 1'b0;
    exp_ov = 1'b0;
    exp_un = 1'b0;
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #2 check_all();
    #4 rst_n = 1'b1;
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, DW'(i));
    cyc(1'b1, 1'b0, DW'(99));
    for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, rnd());
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, (i % 3 == 0) ? PAT : (i % 3 == 1) ? ~PAT : rnd());
    while (q.size() < D) cyc(1'b1, 1'b0, rnd());
    cyc(1'b1, 1'b1, rnd());
    chk("full_wr_rd_count", DW'(count), DW'(D - 1));
    while (q.size() > 0) cyc(1'b0, 1'b1, '0);
    cyc(1'b1, 1'b1, PAT);
    chk("empty_wr_rd_count", DW'(count), DW'(1));
    cyc(1'b0, 1'b1, '0);
    chk("pat_slices", data_out, PAT);
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, rnd());
    wr = 1'b1;
    data_in = rnd();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
